// File: rtl/qarb_pkg.sv
// rtl/qarb_pkg.sv - shared state encoding, width helper and round-robin pick function
package qarb_pkg;

    // Upper bound on requesters; sizes the padded request vector of rr_pick.
    localparam int MAX_IN = 16;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns 1 when any of valid[n-1:0] is set; idx is the first set bit
    // found searching ptr, ptr+1, ... and wrapping from n-1 back to 0.
    function automatic logic rr_pick(
        input  logic [MAX_IN-1:0] valid,
        input  int                ptr,
        input  int                n,
        output int                idx
    );
        logic found;
        int   k;
        found = 1'b0;
        idx   = 0;
        for (int j = 0; j < MAX_IN; j++) begin
            k = ptr + j;
            if (k >= n) begin
                k = k - n;
            end
            if (!found && (j < n) && valid[4'(k)]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/qround_robin_arbiter_if.sv
// rtl/qround_robin_arbiter_if.sv - valid/ready queue stream interface
// Ports (signals):
//   data   W-bit beat payload, eot flags in the top bits
//   dvalid producer has a beat
//   dready consumer accepts the beat this cycle
interface qround_robin_arbiter_if #(
    parameter int W = 8
) ();
    logic [W-1:0] data;
    logic         dvalid;
    logic         dready;

    modport producer (output data, output dvalid, input dready);
    modport consumer (input data, input dvalid, output dready);
endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin request picker
// Ports:
//   req_i       NUM_IN request vector
//   ptr_i       index with highest priority this round
//   found_o     any request present
//   grant_oh_o  one-hot pick (zero when nothing found)
//   grant_idx_o binary pick
module rr_priority_picker
    import qarb_pkg::*;
#(
    parameter int  NUM_IN = 2,
    localparam int IDX_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic              found_o,
    output logic [NUM_IN-1:0] grant_oh_o,
    output logic [IDX_W-1:0]  grant_idx_o
);

    int pick;

    always_comb begin
        pick        = 0;
        grant_oh_o  = '0;
        found_o     = rr_pick(MAX_IN'(req_i), int'(ptr_i), NUM_IN, pick);
        grant_idx_o = IDX_W'(pick);
        for (int i = 0; i < NUM_IN; i++) begin
            grant_oh_o[i] = found_o && (pick == i);
        end
    end

endmodule

// File: rtl/qround_robin_arbiter.sv
// rtl/qround_robin_arbiter.sv - transaction-granular round-robin merge of queue streams
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   din        NUM_IN requester streams, data = {eot[LVL-1:0], payload[TDIN-1:0]}
//   dout       merged stream, data = {idx, eot, payload}
//   busy       a grant is held
//   grant_idx  granted requester, meaningful while busy
module qround_robin_arbiter
    import qarb_pkg::*;
#(
    parameter int  NUM_IN = 2,
    parameter int  TDIN   = 16,
    parameter int  LVL    = 1,
    localparam int IDX_W  = idx_width(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    qround_robin_arbiter_if.consumer din [NUM_IN],
    qround_robin_arbiter_if.producer dout,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx
);

    localparam int DIN_W = TDIN + LVL;

    logic [NUM_IN-1:0] in_valid;
    logic [NUM_IN-1:0] in_ready;
    logic [DIN_W-1:0]  in_data [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_port
        assign in_valid[i]   = din[i].dvalid;
        assign in_data[i]    = din[i].data;
        assign din[i].dready = in_ready[i];
    end

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [NUM_IN-1:0] grant_oh_q, grant_oh_d;

    logic              pick_found;
    logic [NUM_IN-1:0] pick_oh;
    logic [IDX_W-1:0]  pick_idx;

    rr_priority_picker #(
        .NUM_IN (NUM_IN)
    ) u_picker (
        .req_i       (in_valid),
        .ptr_i       (rr_ptr_q),
        .found_o     (pick_found),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    logic             granted;
    logic             sel_valid;
    logic             sel_last;
    logic             beat_done;
    logic [DIN_W-1:0] sel_data;

    assign granted   = (state_q == ST_GRANT);
    // The one-hot copy of the grant keeps the valid/ready paths free of a decoder.
    assign sel_valid = |(grant_oh_q & in_valid);
    assign sel_data  = in_data[grant_q];

    if (LVL == 0) begin : g_plain
        assign sel_last = 1'b1;
    end else begin : g_queue
        // Only the outermost eot closes a transaction; inner levels pass through.
        assign sel_last = sel_data[DIN_W-1];
    end

    assign beat_done   = granted && sel_valid && dout.dready;
    assign dout.dvalid = granted && sel_valid;
    assign dout.data   = {grant_q, sel_data};
    assign in_ready    = grant_oh_q & {NUM_IN{granted && dout.dready}};

    assign busy      = granted;
    assign grant_idx = grant_q;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        if (state_q == ST_IDLE) begin
            // The pick is registered, so a grant always costs one idle cycle.
            if (pick_found) begin
                state_d    = ST_GRANT;
                grant_d    = pick_idx;
                grant_oh_d = pick_oh;
            end
        end else begin
            if (beat_done && sel_last) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
        end
    end

endmodule

// File: tb/tb_qround_robin_arbiter.sv
// tb/tb_qround_robin_arbiter.sv - self-checking bench for qround_robin_arbiter
module tb_qround_robin_arbiter;

    localparam int NUM_IN = 3;
    localparam int TDIN   = 8;
    localparam int LVL    = 2;
    localparam int IDX_W  = 2;
    localparam int DIN_W  = TDIN + LVL;
    localparam int DOUT_W = IDX_W + DIN_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [DIN_W-1:0]  tb_data [NUM_IN];
    logic [NUM_IN-1:0] tb_valid;
    logic [NUM_IN-1:0] tb_ready;
    logic              tb_oready;
    logic              busy;
    logic [IDX_W-1:0]  grant_idx;

    int checks = 0;
    int errors = 0;

    qround_robin_arbiter_if #(.W(DIN_W))  din_if [NUM_IN] ();
    qround_robin_arbiter_if #(.W(DOUT_W)) dout_if ();

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
        assign din_if[gi].data   = tb_data[gi];
        assign din_if[gi].dvalid = tb_valid[gi];
        assign tb_ready[gi]      = din_if[gi].dready;
    end
    assign dout_if.dready = tb_oready;

    qround_robin_arbiter #(
        .NUM_IN (NUM_IN),
        .TDIN   (TDIN),
        .LVL    (LVL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din_if),
        .dout      (dout_if),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        tb_valid  = '0;
        tb_oready = 1'b0;
        for (int i = 0; i < NUM_IN; i++) tb_data[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tb_valid  = '1;
        tb_oready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) tb_data[i] = {2'b10, 8'(i)};
        step();
        step();
        #1;
        checks++; if (dout_if.dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", dout_if.dvalid); end
        checks++; if (tb_ready !== 3'b000) begin errors++; $display("FAIL reset_dready got %b exp 000", tb_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_idx); end
        rst = 1'b1;
        step();
        #1;
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL reset_first_grant got busy=%b idx=%0d exp busy=1 idx=0", busy, grant_idx); end
        checks++; if (dout_if.dvalid !== 1'b1 || dout_if.data !== {2'd0, 2'b10, 8'd0}) begin errors++; $display("FAIL reset_first_beat got v=%b d=%h exp v=1 d=%h", dout_if.dvalid, dout_if.data, {2'd0, 2'b10, 8'd0}); end
        clear_inputs();
    endtask

    task automatic test_lock();
        logic [DIN_W-1:0] beat;
        do_reset();
        tb_oready  = 1'b1;
        tb_valid   = 3'b011;
        tb_data[0] = {2'b00, 8'h20};
        tb_data[1] = {2'b10, 8'h11};
        #1;
        checks++; if (dout_if.dvalid !== 1'b0) begin errors++; $display("FAIL lock_arb_cycle got %b exp 0", dout_if.dvalid); end
        step();
        for (int b = 0; b < 3; b++) begin
            beat = {(b == 2) ? 2'b10 : 2'b00, 8'(8'h20 + b)};
            tb_data[0] = beat;
            #1;
            checks++; if (dout_if.dvalid !== 1'b1 || dout_if.data !== {2'd0, beat}) begin errors++; $display("FAIL lock_beat%0d got v=%b d=%h exp v=1 d=%h", b, dout_if.dvalid, dout_if.data, {2'd0, beat}); end
            checks++; if (tb_ready !== 3'b001) begin errors++; $display("FAIL lock_ready%0d got %b exp 001", b, tb_ready); end
            step();
        end
        tb_valid[0] = 1'b0;
        #1;
        checks++; if (dout_if.dvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lock_gap got v=%b busy=%b exp 0 0", dout_if.dvalid, busy); end
        step();
        #1;
        checks++; if (dout_if.dvalid !== 1'b1 || dout_if.data !== {2'd1, 2'b10, 8'h11}) begin errors++; $display("FAIL lock_next got v=%b d=%h exp v=1 d=%h", dout_if.dvalid, dout_if.data, {2'd1, 2'b10, 8'h11}); end
        step();
        clear_inputs();
    endtask

    task automatic test_rr_wrap();
        logic [1:0] exp_idx;
        logic       exp_v;
        do_reset();
        tb_oready = 1'b1;
        tb_valid  = '1;
        for (int i = 0; i < NUM_IN; i++) tb_data[i] = {2'b10, 8'(8'h30 + i)};
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_v   = (c % 2 == 1);
            exp_idx = 2'((c / 2) % 3);
            checks++; if (dout_if.dvalid !== exp_v) begin errors++; $display("FAIL rr_valid c%0d got %b exp %b", c, dout_if.dvalid, exp_v); end
            if (exp_v) begin
                checks++; if (dout_if.data[DOUT_W-1 -: IDX_W] !== exp_idx) begin errors++; $display("FAIL rr_idx c%0d got %0d exp %0d", c, dout_if.data[DOUT_W-1 -: IDX_W], exp_idx); end
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        logic [DOUT_W-1:0] got [$];
        logic [DOUT_W-1:0] exp;
        int k    = 0;
        int drop = 0;
        int cyc  = 0;
        do_reset();
        tb_valid[1] = 1'b1;
        tb_data[1]  = {2'b10, 8'h77};
        while (got.size() < 4 && cyc < 40) begin
            if (k < 4 && drop == 0) begin
                tb_valid[0] = 1'b1;
                tb_data[0]  = {(k == 3) ? 2'b10 : 2'b00, 8'(8'hA0 + k)};
            end else begin
                tb_valid[0] = 1'b0;
            end
            tb_oready = cyc[0];
            #1;
            if (busy === 1'b1) begin
                checks++; if (grant_idx !== 2'd0 || tb_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_hold c%0d got idx=%0d rdy1=%b exp idx=0 rdy1=0", cyc, grant_idx, tb_ready[1]); end
            end
            if (dout_if.dvalid === 1'b1 && tb_oready) begin
                got.push_back(dout_if.data);
                k++;
                if (k == 2) drop = 2;
            end else if (drop > 0 && tb_valid[0] == 1'b0) begin
                drop--;
            end
            step();
            cyc++;
        end
        tb_valid[0] = 1'b0;
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count got %0d beats exp 4", got.size()); end
        for (int b = 0; b < got.size() && b < 4; b++) begin
            exp = {2'd0, (b == 3) ? 2'b10 : 2'b00, 8'(8'hA0 + b)};
            checks++; if (got[b] !== exp) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", b, got[b], exp); end
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%b exp 0", busy); end
        clear_inputs();
    endtask

    task automatic test_inner_eot();
        logic [1:0] eot_tab [3];
        eot_tab = '{2'b01, 2'b01, 2'b11};
        do_reset();
        tb_oready  = 1'b1;
        tb_valid   = 3'b100;
        tb_data[2] = {2'b01, 8'd5};
        step();
        tb_valid[0] = 1'b1;
        tb_data[0]  = {2'b10, 8'hEE};
        for (int b = 0; b < 3; b++) begin
            tb_data[2] = {eot_tab[b], 8'(5 + b)};
            #1;
            checks++; if (busy !== 1'b1 || grant_idx !== 2'd2) begin errors++; $display("FAIL inner_hold%0d got busy=%b idx=%0d exp busy=1 idx=2", b, busy, grant_idx); end
            checks++; if (dout_if.data !== {2'd2, eot_tab[b], 8'(5 + b)}) begin errors++; $display("FAIL inner_beat%0d got %h exp %h", b, dout_if.data, {2'd2, eot_tab[b], 8'(5 + b)}); end
            step();
        end
        tb_valid[2] = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inner_release got busy=%b exp 0", busy); end
        step();
        #1;
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL inner_next got busy=%b idx=%0d exp busy=1 idx=0", busy, grant_idx); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tb_oready  = 1'b1;
        tb_valid   = 3'b001;
        tb_data[0] = {2'b10, 8'h01};
        step();
        step();
        tb_valid   = 3'b010;
        tb_data[1] = {2'b00, 8'h40};
        step();
        step();
        tb_data[1] = {2'b00, 8'h41};
        step();
        tb_data[1] = {2'b00, 8'h42};
        #1;
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd1) begin errors++; $display("FAIL rmid_pre got busy=%b idx=%0d exp busy=1 idx=1", busy, grant_idx); end
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || dout_if.dvalid !== 1'b0 || tb_ready !== 3'b000) begin errors++; $display("FAIL rmid_in_reset got busy=%b v=%b rdy=%b exp 0 0 000", busy, dout_if.dvalid, tb_ready); end
        step();
        tb_valid   = 3'b011;
        tb_data[0] = {2'b10, 8'h02};
        rst = 1'b1;
        step();
        #1;
        checks++; if (busy !== 1'b1 || grant_idx !== 2'd0) begin errors++; $display("FAIL rmid_regrant got busy=%b idx=%0d exp busy=1 idx=0", busy, grant_idx); end
        clear_inputs();
    endtask

    task automatic test_random();
        int                left  [NUM_IN];
        bit                first [NUM_IN];
        int                waits [NUM_IN];
        int                m_owner;
        int                m_ptr;
        int                cand;
        bit                m_hold;
        logic [NUM_IN-1:0] hs;
        logic              exp_v;
        do_reset();
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            left[i]  = 0;
            first[i] = 1'b0;
            waits[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!tb_valid[i] && $urandom_range(0, 99) < 45) begin
                    if (left[i] == 0) begin
                        left[i]  = $urandom_range(1, 4);
                        first[i] = 1'b1;
                    end
                    tb_valid[i] = 1'b1;
                    tb_data[i]  = {left[i] == 1, 1'($urandom), 8'($urandom)};
                end
            end
            tb_oready = ($urandom_range(0, 99) < 70);
            #1;
            exp_v = m_hold && tb_valid[m_owner];
            checks++; if (dout_if.dvalid !== exp_v) begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, dout_if.dvalid, exp_v); end
            if (exp_v) begin
                checks++; if (dout_if.data !== {2'(m_owner), tb_data[m_owner]}) begin errors++; $display("FAIL rnd_data c%0d got %h exp %h", c, dout_if.data, {2'(m_owner), tb_data[m_owner]}); end
            end
            checks++; if (busy !== m_hold) begin errors++; $display("FAIL rnd_busy c%0d got %b exp %b", c, busy, m_hold); end
            if (m_hold) begin
                checks++; if (grant_idx !== 2'(m_owner)) begin errors++; $display("FAIL rnd_grant c%0d got %0d exp %0d", c, grant_idx, m_owner); end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                checks++; if (tb_ready[i] !== (m_hold && i == m_owner && tb_oready)) begin errors++; $display("FAIL rnd_ready%0d c%0d got %b exp %b", i, c, tb_ready[i], m_hold && i == m_owner && tb_oready); end
            end
            hs = tb_valid & tb_ready;
            for (int i = 0; i < NUM_IN; i++) begin
                if (hs[i] && tb_data[i][DIN_W-1]) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        if (k != i && tb_valid[k] && first[k]) waits[k]++;
                    end
                    checks++; if (waits[i] > NUM_IN - 1) begin errors++; $display("FAIL rnd_fair%0d c%0d waited %0d exp <= %0d", i, c, waits[i], NUM_IN - 1); end
                    waits[i] = 0;
                end
            end
            if (!m_hold) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    cand = (m_ptr + j) % NUM_IN;
                    if (!m_hold && tb_valid[cand]) begin
                        m_owner = cand;
                        m_hold  = 1'b1;
                    end
                end
            end else if (tb_valid[m_owner] && tb_oready && tb_data[m_owner][DIN_W-1]) begin
                m_hold = 1'b0;
                m_ptr  = (m_owner + 1) % NUM_IN;
            end
            step();
            for (int i = 0; i < NUM_IN; i++) begin
                if (hs[i]) begin
                    tb_valid[i] = 1'b0;
                    left[i]     = left[i] - 1;
                    first[i]    = 1'b0;
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_lock();
        test_rr_wrap();
        test_backpressure();
        test_inner_eot();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
